t03_dpu_frame_scheduler: RTL and testbench
==========================================

T03_DPU_FRAME_SCHEDULER -- requirements
Module: t03_dpu_frame_scheduler

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1056, horizontal counts per line.
REQ-002 SHALL have parameter V_ACTIVE, default 600, first non-visible line.
REQ-003 SHALL have parameter V_TOTAL, default 628, lines per frame.
REQ-004 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period.
REQ-005 SHALL have one clock and a synchronous, active-high reset, stated exactly so: clk in 1 (sole clock); rst in 1 (synchronous, active-high).
REQ-006 SHALL have ports Hcnt in 11 and Vcnt in 11, both from the display counters.
REQ-007 SHALL have port upd_valid in 1, game logic offering a new snapshot.
REQ-008 SHALL have port upd_ready out 1, snapshot accepted this cycle if upd_valid is also high.
REQ-009 SHALL have input ports x1, x2, y1, y2 (11 each), p1State, p2State (2 each), p1Left, p2Left (1 each), gameState (3), p1health, p2health (4 each).
REQ-010 SHALL have output ports x1_q, x2_q, y1_q, y2_q, p1State_q, p2State_q, p1Left_q, p2Left_q, gameState_q, p1health_q, p2health_q: registered copies of the inputs in REQ-009, same widths.
REQ-011 SHALL have outputs frame_start (1, one-cycle pulse), missed_frame (1, one-cycle pulse), blink (1) and frame_cnt (6).

Function
REQ-012 SHALL implement FSM states ACTIVE, OPEN and DONE.
REQ-013 ACTIVE SHALL move to OPEN on the cycle Vcnt==V_ACTIVE and Hcnt==0.
REQ-014 upd_ready SHALL be high only in OPEN, and SHALL be a registered state decode, not a function of upd_valid.
REQ-015 In OPEN, upd_valid&&upd_ready SHALL load all REQ-009 inputs into the _q registers, visible the next cycle, and move to DONE.
REQ-016 The _q registers SHALL change only on an accepted handshake or on reset, so they are constant throughout the visible area.
REQ-017 OPEN or DONE SHALL move to ACTIVE on the cycle Vcnt==V_TOTAL-1 and Hcnt==H_TOTAL-1 (end of frame).
REQ-018 frame_start SHALL pulse on the cycle after the end of frame (Vcnt==0, Hcnt==0).
REQ-019 If OPEN reaches end of frame without a handshake, missed_frame SHALL pulse on that same cycle and the _q registers SHALL hold their values.
REQ-020 Simultaneous events: upd_valid high on the end-of-frame cycle while in OPEN SHALL be accepted, with no missed_frame pulse and a return to ACTIVE.
REQ-021 Only one snapshot SHALL be accepted per frame; DONE SHALL hold upd_ready low.
REQ-022 Vcnt/Hcnt values outside range SHALL not deadlock: ACTIVE waits, and OPEN/DONE exit only via REQ-017.
REQ-023 frame_cnt SHALL increment on each frame_start and wrap from BLINK_FRAMES-1 to 0.
REQ-024 blink SHALL toggle on each wrap of frame_cnt.
REQ-025 Width rules: all outputs SHALL be unsigned; no arithmetic is applied to the snapshot values (the y inversion stays downstream).

Reset
REQ-026 While rst is high at a clk edge, the FSM SHALL go to ACTIVE, all _q registers, frame_cnt and blink to 0, and upd_ready, frame_start and missed_frame to 0.
REQ-027 Reset asserted in OPEN or DONE SHALL abandon the window with no missed_frame pulse; the next OPEN SHALL occur only per REQ-013.
REQ-028 The first cycle after reset release SHALL produce no frame_start, even if Vcnt==0 and Hcnt==0.

Structure
REQ-029 Package t03_dpu_pkg SHALL hold the FSM state typedef (2-bit enum) and default timing constants (H_TOTAL, V_ACTIVE, V_TOTAL).
REQ-030 The snapshot register bank SHALL be one sub-module, t03_dpu_snapshot_regs (load enable plus reset), instantiated once.
REQ-031 The FSM, frame counter and blink logic SHALL reside in the top module.

Verification
REQ-032 Test 1: upd_valid held high, x1=100 -> upd_ready rises at Vcnt=600/Hcnt=0, x1_q=100 the next cycle, upd_ready low one cycle later.
REQ-033 Test 2: upd_valid held low all frame -> missed_frame pulses at Vcnt=627/Hcnt=1055 and the _q registers are unchanged.
REQ-034 Test 3: upd_valid asserted only at Vcnt=627/Hcnt=1055 -> accepted, no missed_frame, frame_start pulses the next cycle.
REQ-035 Test 4: two upd_valid pulses in one vblank with different x2 -> only the first value is latched.
REQ-036 Test 5: 60 frames with BLINK_FRAMES=30 -> frame_cnt wraps twice and blink returns to 0.
REQ-037 Test 6: rst pulsed at Vcnt=610 in OPEN -> outputs 0, no missed_frame, upd_ready next high at the following Vcnt=600.

Source files
------------

// File: rtl/t03_dpu_pkg.sv
// Shared types and default timing for the display frame scheduler.
// The snapshot struct groups every game-state field latched once per frame.
package t03_dpu_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_OPEN   = 2'd1,
    ST_DONE   = 2'd2
  } dpu_state_e;

  localparam int unsigned DEF_H_TOTAL  = 1056;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_TOTAL  = 628;

  typedef struct packed {
    logic [10:0] x1;
    logic [10:0] x2;
    logic [10:0] y1;
    logic [10:0] y2;
    logic [1:0]  p1_state;
    logic [1:0]  p2_state;
    logic        p1_left;
    logic        p2_left;
    logic [2:0]  game_state;
    logic [3:0]  p1_health;
    logic [3:0]  p2_health;
  } snapshot_t;

endpackage

// File: rtl/t03_dpu_snapshot_regs.sv
// Snapshot register bank: captures a full game-state snapshot on load.
// Holds its contents otherwise, so the display sees a stable frame.
module t03_dpu_snapshot_regs
  import t03_dpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  snapshot_t d,
  output snapshot_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/t03_dpu_frame_scheduler.sv
// Frame scheduler: opens a vblank window for one snapshot handshake per
// frame, flags missed frames, and runs the frame counter and blink.
module t03_dpu_frame_scheduler
  import t03_dpu_pkg::*;
#(
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] Hcnt,
  input  logic [10:0] Vcnt,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [10:0] x1,
  input  logic [10:0] x2,
  input  logic [10:0] y1,
  input  logic [10:0] y2,
  input  logic [1:0]  p1State,
  input  logic [1:0]  p2State,
  input  logic        p1Left,
  input  logic        p2Left,
  input  logic [2:0]  gameState,
  input  logic [3:0]  p1health,
  input  logic [3:0]  p2health,
  output logic [10:0] x1_q,
  output logic [10:0] x2_q,
  output logic [10:0] y1_q,
  output logic [10:0] y2_q,
  output logic [1:0]  p1State_q,
  output logic [1:0]  p2State_q,
  output logic        p1Left_q,
  output logic        p2Left_q,
  output logic [2:0]  gameState_q,
  output logic [3:0]  p1health_q,
  output logic [3:0]  p2health_q,
  output logic        frame_start,
  output logic        missed_frame,
  output logic        blink,
  output logic [5:0]  frame_cnt
);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_OPEN  = 11'(V_ACTIVE);
  localparam logic [5:0]  FC_LAST = 6'(BLINK_FRAMES - 1);

  dpu_state_e state, state_next;
  logic       eof;
  logic       win_open;
  logic       accept;
  snapshot_t  snap_d;
  snapshot_t  snap_q;

  assign eof      = (Vcnt == V_LAST) && (Hcnt == H_LAST);
  assign win_open = (Vcnt == V_OPEN) && (Hcnt == 11'd0);

  // Ready is a pure decode of the state flop, never of upd_valid.
  assign upd_ready = (state == ST_OPEN);
  assign accept    = upd_ready && upd_valid;

  // Accepting on the end-of-frame cycle itself counts as a delivered frame.
  assign missed_frame = (state == ST_OPEN) && eof && !upd_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACTIVE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACTIVE: if (win_open) state_next = ST_OPEN;
      ST_OPEN: begin
        if (eof)         state_next = ST_ACTIVE;
        else if (accept) state_next = ST_DONE;
      end
      ST_DONE:   if (eof) state_next = ST_ACTIVE;
      default:   state_next = ST_ACTIVE;
    endcase
  end

  assign snap_d = {x1, x2, y1, y2, p1State, p2State, p1Left, p2Left,
                   gameState, p1health, p2health};

  t03_dpu_snapshot_regs u_snapshot_regs (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .d    (snap_d),
    .q    (snap_q)
  );

  assign x1_q        = snap_q.x1;
  assign x2_q        = snap_q.x2;
  assign y1_q        = snap_q.y1;
  assign y2_q        = snap_q.y2;
  assign p1State_q   = snap_q.p1_state;
  assign p2State_q   = snap_q.p2_state;
  assign p1Left_q    = snap_q.p1_left;
  assign p2Left_q    = snap_q.p2_left;
  assign gameState_q = snap_q.game_state;
  assign p1health_q  = snap_q.p1_health;
  assign p2health_q  = snap_q.p2_health;

  // frame_start lands on the (0,0) cycle following end of frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      blink       <= 1'b0;
    end else begin
      frame_start <= eof;
      if (frame_start) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_t03_dpu_frame_scheduler.sv
// Directed bench for the frame scheduler; counters are driven directly so
// the vblank and end-of-frame points are reached without full scans.
module tb_t03_dpu_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] Hcnt, Vcnt;
  logic        upd_valid, upd_ready;
  logic [10:0] x1, x2, y1, y2;
  logic [1:0]  p1State, p2State;
  logic        p1Left, p2Left;
  logic [2:0]  gameState;
  logic [3:0]  p1health, p2health;
  logic [10:0] x1_q, x2_q, y1_q, y2_q;
  logic [1:0]  p1State_q, p2State_q;
  logic        p1Left_q, p2Left_q;
  logic [2:0]  gameState_q;
  logic [3:0]  p1health_q, p2health_q;
  logic        frame_start, missed_frame, blink;
  logic [5:0]  frame_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  t03_dpu_frame_scheduler dut (
    .clk(clk), .rst(rst), .Hcnt(Hcnt), .Vcnt(Vcnt),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .x1(x1), .x2(x2), .y1(y1), .y2(y2),
    .p1State(p1State), .p2State(p2State), .p1Left(p1Left), .p2Left(p2Left),
    .gameState(gameState), .p1health(p1health), .p2health(p2health),
    .x1_q(x1_q), .x2_q(x2_q), .y1_q(y1_q), .y2_q(y2_q),
    .p1State_q(p1State_q), .p2State_q(p2State_q),
    .p1Left_q(p1Left_q), .p2Left_q(p2Left_q),
    .gameState_q(gameState_q), .p1health_q(p1health_q), .p2health_q(p2health_q),
    .frame_start(frame_start), .missed_frame(missed_frame),
    .blink(blink), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int h);
    Vcnt = 11'(v);
    Hcnt = 11'(h);
    #1;
  endtask

  initial begin
    rst = 1'b1; upd_valid = 1'b0;
    x1 = 0; x2 = 0; y1 = 0; y2 = 0; p1State = 0; p2State = 0;
    p1Left = 0; p2Left = 0; gameState = 0; p1health = 0; p2health = 0;
    drive(0, 0);
    tick(); tick();
    chk("rst_ready", 32'(upd_ready), 0);
    chk("rst_missed", 32'(missed_frame), 0);
    chk("rst_x1q", 32'(x1_q), 0);
    rst = 1'b0;
    tick();
    chk("rel_frame_start", 32'(frame_start), 0);
    chk("rel_frame_cnt", 32'(frame_cnt), 0);
    chk("rel_blink", 32'(blink), 0);

    // Out-of-range counters: ACTIVE just waits
    drive(700, 2000); tick(); tick();
    chk("oor_ready", 32'(upd_ready), 0);

    // Test 1: valid held high
    x1 = 100; y2 = 55; gameState = 3'd5; p2health = 4'd9; p1Left = 1'b1;
    upd_valid = 1'b1;
    drive(600, 0);
    chk("t1_ready_pre", 32'(upd_ready), 0);
    tick();
    chk("t1_ready_open", 32'(upd_ready), 1);
    chk("t1_x1q_pre", 32'(x1_q), 0);
    drive(600, 1); tick();
    chk("t1_x1q", 32'(x1_q), 100);
    chk("t1_y2q", 32'(y2_q), 55);
    chk("t1_gsq", 32'(gameState_q), 5);
    chk("t1_p2hq", 32'(p2health_q), 9);
    chk("t1_p1lq", 32'(p1Left_q), 1);
    chk("t1_ready_done", 32'(upd_ready), 0);
    drive(610, 0); tick();
    chk("t1_ready_done2", 32'(upd_ready), 0);
    drive(627, 1055);
    chk("t1_missed_done", 32'(missed_frame), 0);
    tick();
    chk("t1_frame_start", 32'(frame_start), 1);
    drive(0, 0); tick();
    chk("t1_frame_start_end", 32'(frame_start), 0);
    chk("t1_frame_cnt", 32'(frame_cnt), 1);

    // Test 2: valid low all frame
    upd_valid = 1'b0; x1 = 200;
    drive(600, 0); tick();
    drive(610, 0); tick();
    chk("t2_ready", 32'(upd_ready), 1);
    drive(627, 1055);
    chk("t2_missed", 32'(missed_frame), 1);
    tick();
    chk("t2_missed_after", 32'(missed_frame), 0);
    chk("t2_x1q_hold", 32'(x1_q), 100);
    chk("t2_frame_start", 32'(frame_start), 1);
    drive(0, 0); tick();

    // Test 3: valid only on the end-of-frame cycle
    x1 = 300;
    drive(600, 0); tick();
    chk("t3_ready", 32'(upd_ready), 1);
    drive(627, 1055); upd_valid = 1'b1; #1;
    chk("t3_missed", 32'(missed_frame), 0);
    tick();
    upd_valid = 1'b0;
    chk("t3_x1q", 32'(x1_q), 300);
    chk("t3_ready_after", 32'(upd_ready), 0);
    chk("t3_frame_start", 32'(frame_start), 1);
    drive(0, 0); tick();

    // Test 4: two offers in one vblank
    x2 = 11; upd_valid = 1'b1;
    drive(600, 0); tick();
    drive(600, 1); tick();
    x2 = 22;
    drive(600, 2); tick();
    drive(600, 3); tick();
    upd_valid = 1'b0;
    chk("t4_x2q_first", 32'(x2_q), 11);
    drive(627, 1055); tick();
    drive(0, 0); tick();
    chk("t4_x2q_hold", 32'(x2_q), 11);

    // Test 6: reset in the open window
    drive(600, 0); tick();
    drive(610, 0); tick();
    chk("t6_ready_open", 32'(upd_ready), 1);
    rst = 1'b1; #1;
    chk("t6_missed_rst", 32'(missed_frame), 0);
    tick();
    rst = 1'b0;
    chk("t6_ready", 32'(upd_ready), 0);
    chk("t6_x1q", 32'(x1_q), 0);
    chk("t6_x2q", 32'(x2_q), 0);
    chk("t6_frame_cnt", 32'(frame_cnt), 0);
    drive(611, 0); tick();
    chk("t6_ready_stay", 32'(upd_ready), 0);
    drive(627, 1055);
    chk("t6_missed_eof", 32'(missed_frame), 0);
    tick();
    drive(0, 0); tick();
    drive(600, 0); tick();
    chk("t6_ready_reopen", 32'(upd_ready), 1);

    // Test 5: 60 frames after a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      drive(627, 1055); tick();
      drive(0, 0); tick();
      if (i == 0)  chk("t5_cnt_1", 32'(frame_cnt), 1);
      if (i == 28) chk("t5_cnt_29", 32'(frame_cnt), 29);
      if (i == 29) begin
        chk("t5_wrap1_cnt", 32'(frame_cnt), 0);
        chk("t5_wrap1_blink", 32'(blink), 1);
      end
      if (i == 30) chk("t5_cnt_after_wrap", 32'(frame_cnt), 1);
    end
    chk("t5_wrap2_cnt", 32'(frame_cnt), 0);
    chk("t5_wrap2_blink", 32'(blink), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
